lms_weight_update: RTL and testbench
====================================

// Module: lms_weight_update
// PURPOSE
//  Produces the adaptive complex weight w consumed by the conj(w)*u multiplier path.
//  Complex LMS update: w <= w + mu * u * conj(e), with mu = 2^-MU_SHIFT.
//  Sits in the beamformer feedback loop, one instance per array element; wI/wQ feed that element's multiplier.
//  3-stage pipelined datapath; saturating 18-bit weight register; load and freeze controls.
// PARAMETERS
//  W         18        sample/weight width, signed two's complement
//  FRAC      16        fractional bits of u, e, w (Q2.16)
//  MU_SHIFT  6         step size mu = 2^-MU_SHIFT
//  INIT_I    65536     weight real part after reset (1.0)
//  INIT_Q    0         weight imag part after reset
//  LEAK_SHIFT 12       leakage factor 2^-LEAK_SHIFT (used only with WEIGHT_LEAK_EN)
// PORTS
//  clk       in   1    clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  in_valid  in   1    uinI/uinQ/eI/eQ valid this cycle
//  uinI      in   W    element sample, real
//  uinQ      in   W    element sample, imag
//  eI        in   W    error sample (d - y), real
//  eQ        in   W    error sample, imag
//  freeze    in   1    1 = updates are discarded and w holds
//  w_load    in   1    1 = load w_initI/w_initQ into the weight
//  w_initI   in   W    load value, real
//  w_initQ   in   W    load value, imag
//  wI        out  W    current weight, real
//  wQ        out  W    current weight, imag
//  w_valid   out  1    one-cycle pulse: wI/wQ changed by an update this cycle
//  upd_cnt   out  16   count of applied updates, wraps 65535->0
// BEHAVIOUR
//  - Reset (async on rst_n low): wI=INIT_I, wQ=INIT_Q, w_valid=0, upd_cnt=0, all pipeline valids cleared.
//  - S1 (edge 1): register u, conj(e) = (eI, -eQ), in_valid.
//    -eQ for eQ=-2^17 saturates to 2^17-1.
//  - S2 (edge 2): pI = uI*eI + uQ*eQ; pQ = uQ*eI - uI*eQ.
//    Products are full 36-bit; sums are 37-bit; no truncation.
//  - S3 (edge 3): d = (p + 2^(FRAC+MU_SHIFT-1)) >>> (FRAC+MU_SHIFT).
//    Round half up, arithmetic shift.
//    w <= sat_W(w + d); clamp to [-2^17, 2^17-1].
//    w_valid=1 and upd_cnt++ in the same cycle.
//  - Latency: input sampled at edge 0 -> new weight visible after edge 3.
//    Fully pipelined, one update per cycle; back-to-back valids each apply in order.
//  - freeze=1 sampled at S3: update dropped, w held, w_valid=0, upd_cnt held. The pipeline keeps flowing.
//  - w_load=1: w <= (w_initI, w_initQ) next edge and all in-flight valids are flushed.
//    w_valid=0 on load; upd_cnt is not changed by the load itself.
//    Load has priority over an S3 update in the same cycle, and over freeze.
//  - in_valid=0: datapath registers may toggle; w and upd_cnt must not change.
//  - Reset mid-operation: in-flight updates are lost; state returns to reset values immediately.
// CONFIGURATION
//  WEIGHT_LEAK_EN defined:
//    Leaky LMS; on each applied update, w <= sat_W(w - (w >>> LEAK_SHIFT) + d).
//    Leak is applied only when an update is applied (not when frozen or idle).
//  WEIGHT_LEAK_EN undefined:
//    Plain LMS as above; LEAK_SHIFT is unused; no leak logic is synthesised.
// TESTING (defaults; WEIGHT_LEAK_EN undefined unless stated)
//  1. Reset, u=(65536,0), e=(32768,0), in_valid 1 cycle
//     -> w_valid after 3 edges, wI=66048, wQ=0, upd_cnt=1.
//  2. u=(0,65536), e=(65536,0), one valid
//     -> wQ=1024, wI=65536; the I path shows no cross-term leakage.
//  3. Rounding: u=(65536,0), e=(32,0) -> wI +1.
//     Then e=(-32,0) -> wI +0 (half rounds up).
//  4. w_load to (131000,0), then 4 valids with u=e=(131071,0)
//     -> wI saturates at 131071 and stays there; no wrap to negative.
//  5. freeze=1 over 5 valids -> w and upd_cnt unchanged, w_valid never set.
//     w_load in same cycle as an S3 valid -> load value wins.
//  6. rst_n low for 1 cycle while 3 updates are in flight
//     -> w=(65536,0), upd_cnt=0, no w_valid after release.
//     With WEIGHT_LEAK_EN and test 1 stimulus: wI = 65536-16+512 = 66032.

Source files
------------

// File: rtl/lms_weight_update.sv
// Complex LMS weight update w <= sat(w + 2^-MU_SHIFT * u * conj(e)), three pipeline stages.
// Optional feature macro: WEIGHT_LEAK_EN (leaky LMS, w - (w >>> LEAK_SHIFT) + d per applied update).
module lms_weight_update #(
  parameter int W          = 18,
  parameter int FRAC       = 16,
  parameter int MU_SHIFT   = 6,
  parameter int INIT_I     = 65536,
  parameter int INIT_Q     = 0,
  parameter int LEAK_SHIFT = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [W-1:0] uinI,
  input  logic signed [W-1:0] uinQ,
  input  logic signed [W-1:0] eI,
  input  logic signed [W-1:0] eQ,
  input  logic                freeze,
  input  logic                w_load,
  input  logic signed [W-1:0] w_initI,
  input  logic signed [W-1:0] w_initQ,
  output logic signed [W-1:0] wI,
  output logic signed [W-1:0] wQ,
  output logic                w_valid,
  output logic [15:0]         upd_cnt
);

  localparam int PW  = 2 * W;          // full product width
  localparam int SW  = PW + 1;         // sum of two products
  localparam int RND = FRAC + MU_SHIFT;

  localparam logic signed [W-1:0]  W_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  W_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [SW:0]   ACC_MAX  = {{(SW+2-W){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW:0]   ACC_MIN  = {{(SW+2-W){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [SW:0]   ACC_ONE  = {{SW{1'b0}}, 1'b1};
  localparam logic signed [SW:0]   RND_HALF = ACC_ONE <<< (RND - 1);
  localparam logic signed [W-1:0]  INIT_I_W = W'(INIT_I);
  localparam logic signed [W-1:0]  INIT_Q_W = W'(INIT_Q);

  function automatic logic signed [PW-1:0] sext_pw(input logic signed [W-1:0] x);
    return {{(PW-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [SW:0] sext_acc(input logic signed [W-1:0] x);
    return {{(SW+1-W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [SW:0] x);
    if (x > ACC_MAX) return W_MAX;
    if (x < ACC_MIN) return W_MIN;
    return x[W-1:0];
  endfunction

  // ---------------- stage 1: sample u and conj(e) ----------------
  logic signed [W-1:0] s1_ui_reg, s1_uq_reg, s1_ei_reg, s1_ceq_reg;
  logic                s1_valid_reg;
  logic signed [W-1:0] ceq_next;

  // Negating the most negative code would wrap; clamp it to the positive limit.
  assign ceq_next = (eQ == W_MIN) ? W_MAX : -eQ;

  // ---------------- stage 2: complex product u * conj(e) ----------------
  logic signed [PW-1:0] m_ii, m_qc, m_qi, m_ic;
  logic signed [SW-1:0] p_i_next, p_q_next;
  logic signed [SW-1:0] s2_pi_reg, s2_pq_reg;
  logic                 s2_valid_reg;

  assign m_ii = sext_pw(s1_ui_reg) * sext_pw(s1_ei_reg);
  assign m_qc = sext_pw(s1_uq_reg) * sext_pw(s1_ceq_reg);
  assign m_qi = sext_pw(s1_uq_reg) * sext_pw(s1_ei_reg);
  assign m_ic = sext_pw(s1_ui_reg) * sext_pw(s1_ceq_reg);

  // ceq holds -eQ, so uQ*eQ enters the real part as a subtraction.
  assign p_i_next = {m_ii[PW-1], m_ii} - {m_qc[PW-1], m_qc};
  assign p_q_next = {m_qi[PW-1], m_qi} + {m_ic[PW-1], m_ic};

  // ---------------- stage 3: scale, round, accumulate, saturate ----------------
  logic signed [SW:0]  d_i, d_q;
  logic signed [SW:0]  acc_i, acc_q;
  logic signed [W-1:0] wi_reg, wq_reg;
  logic                w_valid_reg;
  logic [15:0]         upd_cnt_reg;

  assign d_i = ($signed({s2_pi_reg[SW-1], s2_pi_reg}) + RND_HALF) >>> RND;
  assign d_q = ($signed({s2_pq_reg[SW-1], s2_pq_reg}) + RND_HALF) >>> RND;

`ifdef WEIGHT_LEAK_EN
  logic signed [W-1:0] leak_i, leak_q;

  assign leak_i = wi_reg >>> LEAK_SHIFT;
  assign leak_q = wq_reg >>> LEAK_SHIFT;
  assign acc_i  = sext_acc(wi_reg) - sext_acc(leak_i) + d_i;
  assign acc_q  = sext_acc(wq_reg) - sext_acc(leak_q) + d_q;
`else
  assign acc_i = sext_acc(wi_reg) + d_i;
  assign acc_q = sext_acc(wq_reg) + d_q;

  generate
    if (LEAK_SHIFT < 0) begin : g_leak_unused
    end
  endgenerate
`endif

  // Datapath registers carry no reset; only the valids and weight state do.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_ui_reg  <= uinI;
      s1_uq_reg  <= uinQ;
      s1_ei_reg  <= eI;
      s1_ceq_reg <= ceq_next;
    end
    s2_pi_reg <= p_i_next;
    s2_pq_reg <= p_q_next;
  end

  // A load flushes everything in flight and outranks both update and freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      wi_reg       <= INIT_I_W;
      wq_reg       <= INIT_Q_W;
      w_valid_reg  <= 1'b0;
      upd_cnt_reg  <= 16'd0;
    end else begin
      s1_valid_reg <= in_valid && !w_load;
      s2_valid_reg <= s1_valid_reg && !w_load;
      w_valid_reg  <= 1'b0;
      if (w_load) begin
        wi_reg <= w_initI;
        wq_reg <= w_initQ;
      end else if (s2_valid_reg && !freeze) begin
        wi_reg      <= sat_w(acc_i);
        wq_reg      <= sat_w(acc_q);
        w_valid_reg <= 1'b1;
        upd_cnt_reg <= upd_cnt_reg + 16'd1;
      end
    end
  end

  assign wI      = wi_reg;
  assign wQ      = wq_reg;
  assign w_valid = w_valid_reg;
  assign upd_cnt = upd_cnt_reg;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed, table-driven bench for lms_weight_update with hand-computed expectations.
module tb_lms_weight_update;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [17:0] uinI, uinQ, eI, eQ;
  logic               freeze;
  logic               w_load;
  logic signed [17:0] w_initI, w_initQ;
  logic signed [17:0] wI, wQ;
  logic               w_valid;
  logic [15:0]        upd_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lms_weight_update dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .uinI    (uinI),
    .uinQ    (uinQ),
    .eI      (eI),
    .eQ      (eQ),
    .freeze  (freeze),
    .w_load  (w_load),
    .w_initI (w_initI),
    .w_initQ (w_initQ),
    .wI      (wI),
    .wQ      (wQ),
    .w_valid (w_valid),
    .upd_cnt (upd_cnt)
  );

  typedef struct {
    bit do_load;
    int li, lq;
    int ui, uq, ei, eq;
    bit frz;
    bit exp_v;
    int exp_wi, exp_wq, exp_cnt;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int bb_e[3]  = '{32768, 65536, 16384};
  int bb_wi[4] = '{512, 1536, 1792, 1792};
  int bb_v[4]  = '{1, 1, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_sample(input int ui, input int uq, input int ei, input int eq);
    uinI = 18'(ui);
    uinQ = 18'(uq);
    eI   = 18'(ei);
    eQ   = 18'(eq);
  endtask

  task automatic do_load(input int li, input int lq);
    w_initI = 18'(li);
    w_initQ = 18'(lq);
    w_load  = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    chk("load_wi", int'(wI), li);
    chk("load_wq", int'(wQ), lq);
    chk("load_valid", int'(w_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // do_load, li, lq, ui, uq, ei, eq, frz, exp_v, exp_wi, exp_wq, exp_cnt
    vecs[0]  = '{1'b0, 0, 0, 65536, 0, 32768, 0, 1'b0, 1'b1, 66048, 0, 1};
    vecs[1]  = '{1'b1, 65536, 0, 0, 65536, 65536, 0, 1'b0, 1'b1, 65536, 1024, 2};
    vecs[2]  = '{1'b0, 0, 0, 65536, 0, 32, 0, 1'b0, 1'b1, 65537, 1024, 3};
    vecs[3]  = '{1'b0, 0, 0, 65536, 0, -32, 0, 1'b0, 1'b1, 65537, 1024, 4};
    vecs[4]  = '{1'b0, 0, 0, 0, 65536, 0, 65536, 1'b0, 1'b1, 66561, 1024, 5};
    vecs[5]  = '{1'b0, 0, 0, 65536, 0, 0, 65536, 1'b0, 1'b1, 66561, 0, 6};
    vecs[6]  = '{1'b0, 0, 0, 65536, 0, 0, -131072, 1'b0, 1'b1, 66561, 2048, 7};
    vecs[7]  = '{1'b0, 0, 0, 65536, 0, 32768, 0, 1'b1, 1'b0, 66561, 2048, 7};
    vecs[8]  = '{1'b1, 131000, 0, 131071, 0, 131071, 0, 1'b0, 1'b1, 131071, 0, 8};
    vecs[9]  = '{1'b0, 0, 0, 131071, 0, 131071, 0, 1'b0, 1'b1, 131071, 0, 9};
    vecs[10] = '{1'b1, -131000, 0, 131071, 0, -131071, 0, 1'b0, 1'b1, -131072, 0, 10};

    rst_n = 1'b0; in_valid = 1'b0; freeze = 1'b0; w_load = 1'b0;
    w_initI = '0; w_initQ = '0;
    drive_sample(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_wi", int'(wI), 65536);
    chk("reset_wq", int'(wQ), 0);
    chk("reset_valid", int'(w_valid), 0);
    chk("reset_cnt", int'(upd_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef WEIGHT_LEAK_EN
    drive_sample(65536, 0, 32768, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("leak_valid", int'(w_valid), 1);
    chk("leak_wi", int'(wI), 66032);
    chk("leak_wq", int'(wQ), 0);
    chk("leak_cnt", int'(upd_cnt), 1);
    $display("leak update: wI=%0d wQ=%0d cnt=%0d", wI, wQ, upd_cnt);
`else
    // Table: one isolated update per entry, weight state carried across entries.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_load) do_load(vecs[i].li, vecs[i].lq);
      freeze = vecs[i].frz;
      drive_sample(vecs[i].ui, vecs[i].uq, vecs[i].ei, vecs[i].eq);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_early_valid", i), int'(w_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), int'(w_valid), int'(vecs[i].exp_v));
      chk($sformatf("v%0d_wi", i), int'(wI), vecs[i].exp_wi);
      chk($sformatf("v%0d_wq", i), int'(wQ), vecs[i].exp_wq);
      chk($sformatf("v%0d_cnt", i), int'(upd_cnt), vecs[i].exp_cnt);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), int'(w_valid), 0);
      freeze = 1'b0;
      $display("vec %0d: u=(%0d,%0d) e=(%0d,%0d) frz=%0d -> w=(%0d,%0d) cnt=%0d",
               i, vecs[i].ui, vecs[i].uq, vecs[i].ei, vecs[i].eq, vecs[i].frz, wI, wQ, upd_cnt);
    end

    // Back-to-back updates apply in order, one per cycle.
    do_load(0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        drive_sample(65536, 0, bb_e[k], 0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("bb%0d_valid", k - 2), int'(w_valid), bb_v[k-2]);
        chk($sformatf("bb%0d_wi", k - 2), int'(wI), bb_wi[k-2]);
      end
    end
    chk("bb_cnt", int'(upd_cnt), 13);
    $display("back-to-back: w=(%0d,%0d) cnt=%0d", wI, wQ, upd_cnt);

    // Positive saturation holds over repeated large updates.
    do_load(131000, 0);
    drive_sample(131071, 0, 131071, 0);
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("sat%0d_valid", k - 2), int'(w_valid), 1);
        chk($sformatf("sat%0d_wi", k - 2), int'(wI), 131071);
      end
    end
    in_valid = 1'b0;
    chk("sat_cnt", int'(upd_cnt), 17);
    $display("saturation: w=(%0d,%0d) cnt=%0d", wI, wQ, upd_cnt);

    // Freeze across five valids: nothing applies.
    freeze = 1'b1;
    drive_sample(65536, 0, 32768, 0);
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 5);
      @(negedge clk);
      chk($sformatf("frz%0d_valid", k), int'(w_valid), 0);
    end
    in_valid = 1'b0;
    chk("frz_wi", int'(wI), 131071);
    chk("frz_wq", int'(wQ), 0);
    chk("frz_cnt", int'(upd_cnt), 17);
    freeze = 1'b0;
    $display("freeze: w=(%0d,%0d) cnt=%0d", wI, wQ, upd_cnt);

    // Load coincident with an S3 update wins and flushes the trailing valids.
    drive_sample(65536, 0, 32768, 0);
    w_initI = 18'(1234);
    w_initQ = 18'(-5678);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      w_load   = (k == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    w_load   = 1'b0;
    chk("ldwin_valid", int'(w_valid), 0);
    chk("ldwin_wi", int'(wI), 1234);
    chk("ldwin_wq", int'(wQ), -5678);
    chk("ldwin_cnt", int'(upd_cnt), 17);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush%0d_valid", k), int'(w_valid), 0);
    end
    chk("flush_wi", int'(wI), 1234);
    $display("load-wins: w=(%0d,%0d) cnt=%0d", wI, wQ, upd_cnt);

    // Asynchronous reset with updates in flight.
    drive_sample(65536, 0, 32768, 0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_wi", int'(wI), 65536);
    chk("arst_wq", int'(wQ), 0);
    chk("arst_cnt", int'(upd_cnt), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("arst%0d_valid", k), int'(w_valid), 0);
    end
    chk("arst_post_wi", int'(wI), 65536);
    chk("arst_post_cnt", int'(upd_cnt), 0);
    $display("reset mid-flight: w=(%0d,%0d) cnt=%0d", wI, wQ, upd_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
